imp_wr_master: RTL and testbench

//  Downstream stage of the image-processing read master: takes the processed pixel stream (one 32b word per

---
 rtl/imp_pkg.sv | 14 +
 rtl/imp_wr_master_if.sv | 42 ++++
 rtl/imp_wr_master_beat.sv | 55 +++++
 rtl/imp_wr_master.sv | 141 ++++++++++++++
 tb/tb_imp_wr_master.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imp_pkg.sv
// Types and constants shared by the IMP read and write masters.
package imp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PIX,
    XFER,
    RESP
  } imp_wr_st_e;

  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam int         IMP_BYTES_PER_PXL = 4;

endpackage

// File: rtl/imp_wr_master_if.sv
// Pixel stream input plus AXI4-lite write channels of the IMP write master.
interface imp_wr_master_if;

  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_data;

  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic [1:0]  mem_axi_bresp;

  modport master (
    input  pix_valid, pix_data,
    output pix_ready,
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_awready,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_wready,
    input  mem_axi_bvalid, mem_axi_bresp,
    output mem_axi_bready
  );

  modport slave (
    output pix_valid, pix_data,
    input  pix_ready,
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_awready,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_wready,
    output mem_axi_bvalid, mem_axi_bresp,
    input  mem_axi_bready
  );

endinterface

// File: rtl/imp_wr_master_beat.sv
// Single-beat AXI4-lite write: AW and W valids retire independently, then one B is awaited.
// Valids are registered so they drop immediately on asynchronous reset.
module imp_axil_wr_beat
  import imp_pkg::*;
(
  input  logic       clk,
  input  logic       PoR_rst_n,
  input  logic       issue_i,
  input  logic       resp_phase_i,
  input  logic       awready_i,
  input  logic       wready_i,
  input  logic       bvalid_i,
  input  logic [1:0] bresp_i,
  output logic       awvalid_o,
  output logic       wvalid_o,
  output logic       bready_o,
  output logic       aw_w_done_o,
  output logic       b_hs_o,
  output logic       b_err_o
);

  logic aw_pend_q, aw_pend_d;
  logic w_pend_q, w_pend_d;

  always_comb begin
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    if (issue_i) begin
      aw_pend_d = 1'b1;
      w_pend_d  = 1'b1;
    end else begin
      if (aw_pend_q && awready_i) aw_pend_d = 1'b0;
      if (w_pend_q && wready_i)   w_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  // Address/data phase is complete once neither channel will still be pending next cycle.
  assign aw_w_done_o = !aw_pend_d && !w_pend_d;
  assign awvalid_o   = aw_pend_q;
  assign wvalid_o    = w_pend_q;
  assign bready_o    = resp_phase_i;
  assign b_hs_o      = resp_phase_i && bvalid_i;
  assign b_err_o     = b_hs_o && (bresp_i != AXI_RESP_OKAY);

endmodule

// File: rtl/imp_wr_master.sv
// Writes an HSIZE x VSIZE pixel stream to memory as single-beat AXI4-lite writes, one outstanding.
// Pixel accepted 2 cycles after IMP_ST rises; min 3 cycles/pixel; pix_ready only while waiting for a pixel.
module imp_wr_master
  import imp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 PoR_rst_n,
  imp_wr_master_if.master      mem_if,
  input  logic [CNT_W-1:0]     IMP_HSIZE,
  input  logic [CNT_W-1:0]     IMP_VSIZE,
  input  logic [31:0]          IMP_DST_BADDR,
  input  logic [31:0]          IMP_ADR_PITCH,
  input  logic                 IMP_ST,
  output logic                 imp_wr_busy,
  output logic                 imp_wr_done,
  output logic                 imp_wr_err
);

  imp_wr_st_e state_q, state_d;

  logic [1:0]        st_dly_q;
  logic [CNT_W-1:0]  hsize_q, vsize_q, x_q, y_q;
  logic [31:0]       pitch_q, row_base_q, awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q, done_q, err_q;

  logic trg, zero_size, row_end, last_pix;
  logic pix_rdy, pix_hs, issue, resp_phase;
  logic awvalid, wvalid, bready, xfer_done, b_hs, b_err;

  assign trg       = (st_dly_q == 2'b01);
  assign zero_size = (IMP_HSIZE == '0) || (IMP_VSIZE == '0);
  assign row_end   = (x_q == hsize_q - 1'b1);
  assign last_pix  = row_end && (y_q == vsize_q - 1'b1);
  assign pix_hs    = pix_rdy && mem_if.pix_valid;

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (trg && !zero_size) state_d = WAIT_PIX;
      WAIT_PIX: if (mem_if.pix_valid)  state_d = XFER;
      XFER:     if (xfer_done)         state_d = RESP;
      RESP:     if (b_hs)              state_d = last_pix ? IDLE : WAIT_PIX;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_rdy    = (state_q == WAIT_PIX);
    issue      = (state_q == WAIT_PIX) && mem_if.pix_valid;
    resp_phase = (state_q == RESP);
  end

  always_ff @(posedge clk or negedge PoR_rst_n) begin
    if (!PoR_rst_n) begin
      st_dly_q   <= 2'b00;
      hsize_q    <= '0;
      vsize_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pitch_q    <= '0;
      row_base_q <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_dly_q <= {st_dly_q[0], IMP_ST};
      done_q   <= 1'b0;
      if (state_q == IDLE && trg) begin
        hsize_q    <= IMP_HSIZE;
        vsize_q    <= IMP_VSIZE;
        pitch_q    <= IMP_ADR_PITCH;
        row_base_q <= IMP_DST_BADDR;
        awaddr_q   <= IMP_DST_BADDR;
        x_q        <= '0;
        y_q        <= '0;
        err_q      <= 1'b0;
        busy_q     <= !zero_size;
        // An empty frame completes immediately without touching the bus.
        done_q     <= zero_size;
      end
      if (pix_hs) wdata_q <= mem_if.pix_data;
      if (b_hs) begin
        err_q <= err_q | b_err;
        if (last_pix) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else if (row_end) begin
          x_q        <= '0;
          y_q        <= y_q + 1'b1;
          row_base_q <= row_base_q + pitch_q;
          awaddr_q   <= row_base_q + pitch_q;
        end else begin
          x_q      <= x_q + 1'b1;
          awaddr_q <= awaddr_q + 32'(IMP_BYTES_PER_PXL);
        end
      end
    end
  end

  imp_axil_wr_beat u_beat (
    .clk          (clk),
    .PoR_rst_n    (PoR_rst_n),
    .issue_i      (issue),
    .resp_phase_i (resp_phase),
    .awready_i    (mem_if.mem_axi_awready),
    .wready_i     (mem_if.mem_axi_wready),
    .bvalid_i     (mem_if.mem_axi_bvalid),
    .bresp_i      (mem_if.mem_axi_bresp),
    .awvalid_o    (awvalid),
    .wvalid_o     (wvalid),
    .bready_o     (bready),
    .aw_w_done_o  (xfer_done),
    .b_hs_o       (b_hs),
    .b_err_o      (b_err)
  );

  assign mem_if.pix_ready       = pix_rdy;
  assign mem_if.mem_axi_awvalid = awvalid;
  assign mem_if.mem_axi_awaddr  = awaddr_q;
  assign mem_if.mem_axi_awprot  = 3'b000;
  assign mem_if.mem_axi_wvalid  = wvalid;
  assign mem_if.mem_axi_wdata   = wdata_q;
  assign mem_if.mem_axi_wstrb   = 4'hF;
  assign mem_if.mem_axi_bready  = bready;

  assign imp_wr_busy = busy_q;
  assign imp_wr_done = done_q;
  assign imp_wr_err  = err_q;

endmodule

// File: tb/tb_imp_wr_master.sv
// Randomized bench for imp_wr_master: a frame-level model predicts addresses, data order and status.
module tb_imp_wr_master;
  import imp_pkg::*;

  logic       clk = 1'b0;
  logic       PoR_rst_n = 1'b0;
  logic [7:0] IMP_HSIZE = '0, IMP_VSIZE = '0;
  logic [31:0] IMP_DST_BADDR = '0, IMP_ADR_PITCH = '0;
  logic       IMP_ST = 1'b0;
  logic       imp_wr_busy, imp_wr_done, imp_wr_err;

  always #5 clk = ~clk;

  imp_wr_master_if bus ();

  imp_wr_master dut (
    .clk           (clk),
    .PoR_rst_n     (PoR_rst_n),
    .mem_if        (bus),
    .IMP_HSIZE     (IMP_HSIZE),
    .IMP_VSIZE     (IMP_VSIZE),
    .IMP_DST_BADDR (IMP_DST_BADDR),
    .IMP_ADR_PITCH (IMP_ADR_PITCH),
    .IMP_ST        (IMP_ST),
    .imp_wr_busy   (imp_wr_busy),
    .imp_wr_done   (imp_wr_done),
    .imp_wr_err    (imp_wr_err)
  );

  int vec_cnt = 0;
  int miscompares = 0;

  // frame model
  int          m_h = 0, m_v = 0, m_n = 0, err_idx = -1;
  logic [31:0] m_base = '0, m_pitch = '0;
  int          pix_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0;
  bit          m_err = 1'b0;
  logic [31:0] pix_q[$];
  logic [31:0] aw_log[$];

  // bus slave knobs (-1 = random 0..3 cycles)
  int pv_pct = 100, aw_dly = 0, w_dly = 0, b_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k);
    logic [31:0] row, col;
    row = k / m_h;
    col = k % m_h;
    return m_base + m_pitch * row + (col << 2);
  endfunction

  function automatic int pick(input int d);
    return (d < 0) ? int'($urandom_range(3)) : d;
  endfunction

  // Memory slave, pixel source and per-cycle compare, all at the falling edge.
  initial begin : bus_proc
    int  aw_wait, w_wait, b_wait, aw_need, w_need, b_need;
    bit  pix_taken, b_taken;
    bus.pix_valid = 1'b0; bus.pix_data = '0;
    bus.mem_axi_awready = 1'b0; bus.mem_axi_wready = 1'b0;
    bus.mem_axi_bvalid = 1'b0; bus.mem_axi_bresp = 2'b00;
    aw_wait = 0; w_wait = 0; b_wait = 0;
    aw_need = 0; w_need = 0; b_need = 0;
    pix_taken = 1'b0; b_taken = 1'b0;
    forever begin
      @(negedge clk);
      if (!PoR_rst_n) begin
        bus.pix_valid = 1'b0; bus.mem_axi_bvalid = 1'b0;
        bus.mem_axi_awready = 1'b0; bus.mem_axi_wready = 1'b0;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        pix_taken = 1'b0; b_taken = 1'b0;
      end else begin
        if (b_taken) begin
          bus.mem_axi_bvalid = 1'b0; b_wait = 0; b_need = pick(b_dly); b_taken = 1'b0;
        end
        if (!bus.pix_valid || pix_taken) begin
          bus.pix_valid = (int'($urandom_range(99)) < pv_pct);
          bus.pix_data  = $urandom;
          pix_taken     = 1'b0;
        end
        bus.mem_axi_awready = bus.mem_axi_awvalid && (aw_wait >= aw_need);
        bus.mem_axi_wready  = bus.mem_axi_wvalid && (w_wait >= w_need);
        if (!bus.mem_axi_bvalid && aw_cnt > b_cnt && w_cnt > b_cnt) begin
          if (b_wait >= b_need) begin
            bus.mem_axi_bvalid = 1'b1;
            bus.mem_axi_bresp  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
          end else b_wait++;
        end

        if (bus.pix_ready) begin
          chk("pix_ready_excl", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid, bus.mem_axi_bready}), 0);
          chk("pix_ready_when", 32'(pix_cnt == b_cnt && pix_cnt < m_n), 1);
        end
        if (bus.mem_axi_awvalid) begin
          chk("aw_per_pixel", 32'(aw_cnt == pix_cnt - 1), 1);
          if (aw_cnt < m_n) chk("awaddr", bus.mem_axi_awaddr, exp_addr(aw_cnt));
          chk("awprot", 32'(bus.mem_axi_awprot), 0);
        end
        if (bus.mem_axi_wvalid) begin
          chk("w_per_pixel", 32'(w_cnt == pix_cnt - 1), 1);
          if (w_cnt < pix_q.size()) chk("wdata", bus.mem_axi_wdata, pix_q[w_cnt]);
          chk("wstrb", 32'(bus.mem_axi_wstrb), 32'hF);
        end
        if (imp_wr_done) begin
          done_cnt++;
          chk("done_after_last_b", b_cnt, m_n);
        end

        if (bus.pix_valid && bus.pix_ready) begin
          pix_q.push_back(bus.pix_data); pix_cnt++; pix_taken = 1'b1;
        end
        if (bus.mem_axi_awvalid && bus.mem_axi_awready) begin
          aw_log.push_back(bus.mem_axi_awaddr); aw_cnt++; aw_wait = 0; aw_need = pick(aw_dly);
        end else if (bus.mem_axi_awvalid) aw_wait++;
        if (bus.mem_axi_wvalid && bus.mem_axi_wready) begin
          w_cnt++; w_wait = 0; w_need = pick(w_dly);
        end else if (bus.mem_axi_wvalid) w_wait++;
        if (bus.mem_axi_bvalid && bus.mem_axi_bready) begin
          if (bus.mem_axi_bresp != AXI_RESP_OKAY) m_err = 1'b1;
          b_cnt++; b_taken = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_clear();
    pix_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; done_cnt = 0;
    m_err = 1'b0; pix_q.delete(); aw_log.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_awvalid", 32'(bus.mem_axi_awvalid), 0);
    chk("rst_wvalid",  32'(bus.mem_axi_wvalid), 0);
    chk("rst_bready",  32'(bus.mem_axi_bready), 0);
    chk("rst_pix_ready", 32'(bus.pix_ready), 0);
    chk("rst_awaddr",  bus.mem_axi_awaddr, 0);
    chk("rst_wdata",   bus.mem_axi_wdata, 0);
    chk("rst_awprot",  32'(bus.mem_axi_awprot), 0);
    chk("rst_wstrb",   32'(bus.mem_axi_wstrb), 32'hF);
    chk("rst_status",  32'({imp_wr_busy, imp_wr_done, imp_wr_err}), 0);
  endtask

  task automatic start_frame(input int h, input int v, input logic [31:0] base,
                             input logic [31:0] pitch, input int eidx);
    model_clear();
    m_h = h; m_v = v; m_n = h * v; m_base = base; m_pitch = pitch; err_idx = eidx;
    IMP_HSIZE = 8'(h); IMP_VSIZE = 8'(v); IMP_DST_BADDR = base; IMP_ADR_PITCH = pitch;
    IMP_ST = 1'b1;
    tick();
    chk("done_before_trg", 32'(imp_wr_done), 0);
    tick();
    if (m_n == 0) begin
      chk("empty_done_pulse", 32'(imp_wr_done), 1);
      chk("empty_busy", 32'(imp_wr_busy), 0);
      tick();
      chk("empty_done_1cyc", 32'(imp_wr_done), 0);
      chk("empty_busy_after", 32'(imp_wr_busy), 0);
    end else begin
      chk("busy_after_start", 32'(imp_wr_busy), 1);
      chk("err_cleared_on_start", 32'(imp_wr_err), 0);
    end
    IMP_ST = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin tick(); t++; end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    tick(3);
    chk("done_pulses", done_cnt, 1);
    chk("pix_count", pix_cnt, m_n);
    chk("aw_count", aw_cnt, m_n);
    chk("w_count", w_cnt, m_n);
    chk("b_count", b_cnt, m_n);
    chk("busy_at_end", 32'(imp_wr_busy), 0);
    chk("err_at_end", 32'(imp_wr_err), 32'(m_err));
  endtask

  initial begin : watchdog
    #3_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] lit1[8] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                             32'h1040, 32'h1044, 32'h1048, 32'h104C};
    logic [31:0] litw[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    int t;

    tick(3);
    check_reset_vals();
    PoR_rst_n = 1'b1;
    tick(2);

    // 4x2 frame, everything always ready
    pv_pct = 100; aw_dly = 0; w_dly = 0; b_dly = 0;
    start_frame(4, 2, 32'h1000, 32'h40, -1);
    wait_done(500);
    for (int i = 0; i < 8; i++)
      chk("frame4x2_addr", (i < aw_log.size()) ? aw_log[i] : 32'hDEAD_BEEF, lit1[i]);
    chk("frame4x2_err", 32'(imp_wr_err), 0);

    // AW/W ordering variants: AW late, W late, both late together
    aw_dly = 3; w_dly = 0; start_frame(2, 2, 32'h2000, 32'h100, -1); wait_done(500);
    aw_dly = 0; w_dly = 3; start_frame(2, 2, 32'h3000, 32'h100, -1); wait_done(500);
    aw_dly = 2; w_dly = 2; start_frame(2, 2, 32'h4000, 32'h100, -1); wait_done(500);

    // error on pixel 3 of 6 is sticky; next start clears it
    aw_dly = 1; w_dly = 0; b_dly = 1;
    start_frame(3, 2, 32'h5000, 32'h20, 2);
    wait_done(500);
    chk("err_sticky_literal", 32'(imp_wr_err), 1);
    start_frame(2, 1, 32'h6000, 32'h20, -1);
    wait_done(500);

    // empty frame
    aw_dly = 0; w_dly = 0; b_dly = 0;
    start_frame(0, 5, 32'h7000, 32'h20, -1);
    wait_done(50);

    // address wrap, retrigger and config changes mid-frame
    start_frame(4, 1, 32'hFFFF_FFF8, 32'h40, -1);
    IMP_HSIZE = 8'd7; IMP_VSIZE = 8'd3; IMP_DST_BADDR = 32'h0; IMP_ADR_PITCH = 32'h4;
    tick();
    IMP_ST = 1'b1;
    tick(2);
    IMP_ST = 1'b0;
    chk("busy_after_retrigger", 32'(imp_wr_busy), 1);
    wait_done(500);
    for (int i = 0; i < 4; i++)
      chk("wrap_addr", (i < aw_log.size()) ? aw_log[i] : 32'hDEAD_BEEF, litw[i]);

    // reset during XFER of pixel 5, then a fresh full frame
    aw_dly = 3; pv_pct = 100;
    start_frame(3, 3, 32'h8000, 32'h80, -1);
    t = 0;
    while (!(pix_cnt == 5 && bus.mem_axi_awvalid) && t < 500) begin tick(); t++; end
    chk("reached_pixel5_xfer", 32'(pix_cnt == 5 && bus.mem_axi_awvalid), 1);
    PoR_rst_n = 1'b0;
    #1;
    chk("async_drop_valids", 32'({bus.mem_axi_awvalid, bus.mem_axi_wvalid, imp_wr_busy}), 0);
    tick(2);
    check_reset_vals();
    model_clear();
    PoR_rst_n = 1'b1;
    tick(2);
    aw_dly = -1;
    start_frame(3, 3, 32'h8000, 32'h80, -1);
    wait_done(1000);
    chk("post_reset_first_addr", (aw_log.size() > 0) ? aw_log[0] : 32'hDEAD_BEEF, 32'h8000);

    // randomized frames
    pv_pct = 60; aw_dly = -1; w_dly = -1; b_dly = -1;
    for (int r = 0; r < 8; r++) begin
      int h, v;
      logic [31:0] base, pitch;
      h = int'($urandom_range(1, 5));
      v = int'($urandom_range(1, 4));
      base  = {$urandom} & 32'hFFFF_FFFC;
      pitch = (r % 2 == 0) ? ({$urandom} & 32'hFFFF_FFFC) : 32'(($urandom_range(1, 64)) * 4);
      start_frame(h, v, base, pitch, int'($urandom_range(0, h * v)));
      wait_done(2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
